load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Data-memory access stage downstream of the CPU decode/execute logic. Accepts
//   one load or store per handshake. Generates byte-lane write enables and
//   replicated store data, and holds a word-aligned request to dmem until it is
//   acknowledged. Returns sign/zero-extended load data for the regfile write-back.
//   Misaligned accesses, illegal funct3 values and memory timeouts are reported
//   as errors.
// PARAMETERS
//   TIMEOUT_CYC  64  max ACCESS cycles waiting for mem_ack before error; 0 = never time out
// PORTS
//   clk         in   1   clock, all state on rising edge
//   reset       in   1   asynchronous, active-low reset
//   req_valid   in   1   execute stage presents an access
//   req_ready   out  1   LSU can accept (high only in IDLE)
//   req_store   in   1   1 = store (S-type), 0 = load (L-type)
//   req_funct3  in   3   idata[14:12] of the instruction
//   req_addr    in   32  byte address (rv1 + imm)
//   req_wdata   in   32  store source (rv2), unaligned in low bits
//   req_rd      in   5   load destination register
//   mem_req     out  1   request to dmem, held until mem_ack
//   mem_addr    out  32  {req_addr[31:2],2'b00}
//   mem_we      out  4   byte-lane write enables (0 for loads)
//   mem_wdata   out  32  lane-replicated store data
//   mem_ack     in   1   dmem completes request this cycle
//   mem_rdata   in   32  dmem read word, valid with mem_ack
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out  32  extended load data (0 for stores/errors)
//   resp_rd     out  5   req_rd for loads; 0 for stores and errors
//   resp_err    out  1   misaligned / illegal funct3 / timeout, valid with resp_valid
// BEHAVIOUR
//   Reset (reset=0, async): state IDLE, timeout counter 0, captured request 0.
//     req_ready=1, all other outputs 0. A reset during ACCESS drops mem_req at once.
//   FSM IDLE -> ACCESS | RESP ; ACCESS -> RESP ; RESP -> IDLE.
//   IDLE: accept on req_valid&req_ready. Capture all req_* fields at that edge.
//     Check the access. Legal: load funct3 in {0,1,2,4,5}; store funct3 in {0,1,2}.
//     Alignment: half needs addr[0]=0, word needs addr[1:0]=0.
//     Illegal or misaligned -> RESP with err=1, no mem_req ever issued.
//     Otherwise -> ACCESS.
//   ACCESS: mem_req=1, mem_addr/mem_we/mem_wdata stable until the ack.
//     On mem_ack: capture the extended rdata -> RESP.
//     Timeout counter increments each ACCESS cycle without an ack.
//     When count==TIMEOUT_CYC-1 with no ack -> RESP, err=1, mem_req drops.
//     mem_ack on the same cycle as the timeout wins (no error).
//   RESP: resp_valid=1 for exactly one cycle, resp_* registered. req_ready=0.
//     Next state is IDLE; counter cleared.
//   mem_ack seen in IDLE or RESP is ignored.
//   Latency (accept edge = cycle 0): ack in first ACCESS cycle -> resp_valid in cycle 2.
//     Error at decode -> resp_valid in cycle 1. Throughput is at most 1 access per 3 cycles.
//   Store lanes, b = addr[1:0]:
//     SB: we=4'b0001<<b, wdata={4{rv2[7:0]}}
//     SH: we=4'b0011<<{addr[1],1'b0}, wdata={2{rv2[15:0]}}
//     SW: we=4'b1111, wdata=rv2
//   Load extract: LB/LBU byte rdata[8b+7:8b], sign/zero-extended to 32.
//     LH/LHU select rdata[31:16] if addr[1], else rdata[15:0]. LW takes the full word.
// TESTING
//   LW addr 0x100, ack after 1 cycle, rdata 0xDEADBEEF -> mem_addr 0x100, we 0;
//     resp_rdata 0xDEADBEEF, rd echoed, err 0, resp_valid at cycle 2.
//   LB/LBU addr 0x103, rdata 0x80112233 -> LB 0xFFFFFF80, LBU 0x00000080,
//     mem_addr 0x100.
//   SB addr 0x202 rv2 0x000000A5 -> we 4'b0100, wdata 0xA5A5A5A5;
//     SH addr 0x202 -> we 4'b1100, wdata {2{rv2[15:0]}}.
//   LH addr 0x101 and SW addr 0x102 -> resp_err=1 one cycle after accept,
//     mem_req never asserted, resp_rd 0.
//   ACCESS with no mem_ack, TIMEOUT_CYC=4 -> mem_req high exactly 4 cycles,
//     then resp_err=1; late mem_ack in IDLE ignored.
//   reset low mid-ACCESS -> mem_req/resp_valid 0 immediately, req_ready 1;
//     next LW after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: takes one load or store per handshake, drives a word-aligned
// dmem request until it is acknowledged, and returns extended load data.
// Decode errors (illegal funct3, misalignment) and memory timeouts are reported
// on the response instead of reaching memory.

// Per-byte-lane store steering: write enable and data byte for one lane.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [2:0]  funct3,
  input  logic [1:0]  boff,
  input  logic [31:0] rv2,
  output logic        we,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L = 2'(LANE);

  // funct3[1:0] picks the access size; the byte/half source is replicated across lanes
  always_comb begin
    we    = 1'b0;
    wbyte = rv2[8*LANE +: 8];
    case (funct3[1:0])
      2'd0: begin
        we    = (boff == L);
        wbyte = rv2[7:0];
      end
      2'd1: begin
        we    = (boff[1] == L[1]);
        wbyte = rv2[8*(LANE%2) +: 8];
      end
      default: we = 1'b1;
    endcase
  end
endmodule

module load_store_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err
);
  localparam int NUM_LANES = 4;
  // Counter only needs to reach TIMEOUT_CYC-1
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } resp_t;

  state_t  state, state_nxt;
  req_t    cap;
  resp_t   rsp;
  logic [CW-1:0] cnt;

  logic accept, f3_ok, aligned, req_ok, timeout;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wd;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld_data;

  assign accept  = req_valid && (state == S_IDLE);
  // TIMEOUT_CYC==0 disables the timeout entirely
  assign timeout = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1));

  // Decode check on the incoming request: legal funct3 and natural alignment
  always_comb begin
    if (req_store) f3_ok = (req_funct3 <= 3'd2);
    else           f3_ok = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) && (req_funct3 != 3'd7);
    case (req_funct3[1:0])
      2'd1:    aligned = ~req_addr[0];
      2'd2:    aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    req_ok = f3_ok && aligned;
  end

  // Store lane steering, one instance per byte lane
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .funct3 (cap.funct3),
      .boff   (cap.addr[1:0]),
      .rv2    (cap.wdata),
      .we     (lane_we[i]),
      .wbyte  (lane_wd[i])
    );
  end

  // Load extract: select byte/half from the returned word and extend
  always_comb begin
    bsel = mem_rdata[{cap.addr[1:0], 3'b000} +: 8];
    hsel = cap.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (cap.funct3)
      3'd0:    ld_data = {{24{bsel[7]}}, bsel};
      3'd4:    ld_data = {24'd0, bsel};
      3'd1:    ld_data = {{16{hsel[15]}}, hsel};
      3'd5:    ld_data = {16'd0, hsel};
      default: ld_data = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: bad requests skip memory; ack takes priority over timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = req_ok ? S_ACCESS : S_RESP;
      S_ACCESS: if (mem_ack || timeout) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request capture, timeout counter and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap <= '0;
      rsp <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cap <= '{store: req_store, funct3: req_funct3, addr: req_addr,
                   wdata: req_wdata, rd: req_rd};
          rsp <= '{rdata: 32'd0, rd: 5'd0, err: !req_ok};
        end
        S_ACCESS: begin
          if (mem_ack) begin
            rsp <= '{rdata: cap.store ? 32'd0 : ld_data,
                     rd:    cap.store ? 5'd0  : cap.rd,
                     err:   1'b0};
            cnt <= '0;
          end else if (timeout) begin
            rsp <= '{rdata: 32'd0, rd: 5'd0, err: 1'b1};
            cnt <= '0;
          end else if (TIMEOUT_CYC != 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP:  cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs are pure functions of state so reset drops them immediately
  always_comb begin
    req_ready  = (state == S_IDLE);
    mem_req    = (state == S_ACCESS);
    mem_addr   = mem_req ? {cap.addr[31:2], 2'b00} : 32'd0;
    mem_we     = (mem_req && cap.store) ? lane_we : 4'd0;
    mem_wdata  = (mem_req && cap.store) ? lane_wd : 32'd0;
    resp_valid = (state == S_RESP);
    resp_rdata = resp_valid ? rsp.rdata : 32'd0;
    resp_rd    = resp_valid ? rsp.rd    : 5'd0;
    resp_err   = resp_valid ? rsp.err   : 1'b0;
  end
endmodule
